// File: rtl/cam_ctrl.sv
// cam_ctrl: arbitrates a lookup stream against single-entry writes into an
// external CAM core. Lookups are pipelined with a fixed match latency.
// Writes drain every in-flight lookup, issue one CAM_WE cycle, then wait out
// CAM_BUSY before acknowledging.
module cam_ctrl #(
   parameter int C_TCAM_ADDR_WIDTH = 5,
   parameter int C_TCAM_DATA_WIDTH = 16,
   parameter int C_LOOKUP_LATENCY  = 2,
   parameter int C_WR_STARVE_MAX   = 8
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   // configuration write port
   input  logic                         CFG_WR_REQ,
   input  logic [C_TCAM_ADDR_WIDTH-1:0] CFG_WR_ADDR,
   input  logic [C_TCAM_DATA_WIDTH-1:0] CFG_WR_DATA,
   output logic                         CFG_WR_ACK,
   // lookup port
   input  logic                         LU_REQ,
   input  logic [C_TCAM_DATA_WIDTH-1:0] LU_KEY,
   output logic                         LU_RDY,
   output logic                         LU_RSP_VLD,
   output logic                         LU_RSP_HIT,
   output logic [C_TCAM_ADDR_WIDTH-1:0] LU_RSP_ADDR,
   // CAM core
   output logic                         CAM_WE,
   output logic [C_TCAM_ADDR_WIDTH-1:0] CAM_ADDR_WR,
   output logic [C_TCAM_DATA_WIDTH-1:0] CAM_DIN,
   input  logic                         CAM_BUSY,
   output logic [C_TCAM_DATA_WIDTH-1:0] CAM_CMP_DIN,
   input  logic                         CAM_MATCH,
   input  logic [C_TCAM_ADDR_WIDTH-1:0] CAM_MATCH_ADDR
);

   typedef enum logic [1:0] {IDLE, DRAIN, WRITE, WAIT_BUSY} state_t;

   localparam int         LAT        = C_LOOKUP_LATENCY;
   localparam logic [7:0] STARVE_MAX = 8'(C_WR_STARVE_MAX);

   state_t       state, state_nxt;
   logic [LAT:0] vld_pipe;    // [0] loads on accept, [LAT] lines up with CAM_MATCH
   logic [7:0]   starve_cnt;
   logic         wb_min;      // set once WAIT_BUSY has lasted one cycle
   logic         starve_hit;
   logic         in_flight;
   logic         lu_acc;
   logic         tag_out;

   assign starve_hit = CFG_WR_REQ && (starve_cnt == STARVE_MAX);
   assign in_flight  = |vld_pipe;
   assign tag_out    = vld_pipe[LAT];
   // RSTN gates the ready so it reads 0 for the whole time reset is held
   assign LU_RDY     = RSTN && (state == IDLE) && !CAM_BUSY && !starve_hit;
   assign lu_acc     = LU_REQ && LU_RDY;
   // BUSY is ignored in the first WAIT_BUSY cycle since the core may raise it late
   assign CFG_WR_ACK = (state == WAIT_BUSY) && wb_min && !CAM_BUSY;

   // next-state: a lookup wins over a write until the starve limit is hit
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (CFG_WR_REQ && (!LU_REQ || starve_hit)) state_nxt = DRAIN;
         DRAIN:     if (!CFG_WR_REQ)                           state_nxt = IDLE;
                    else if (!in_flight)                       state_nxt = WRITE;
         WRITE:                                                state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (CFG_WR_ACK)                            state_nxt = IDLE;
         default:                                              state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state <= IDLE;
      else       state <= state_nxt;
   end

   // WAIT_BUSY minimum-length tracker; clears during WRITE before every entry
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) wb_min <= 1'b0;
      else       wb_min <= (state == WAIT_BUSY);
   end

   // in-flight lookup tags
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[LAT-1:0], lu_acc};
   end

   // count lookups that overtook a pending write; reset when the write issues
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)                                              starve_cnt <= '0;
      else if (state_nxt == WRITE)                            starve_cnt <= '0;
      else if (lu_acc && CFG_WR_REQ && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 8'd1;
   end

   // registered CAM write strobe and operands, live only in WRITE
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         CAM_WE      <= 1'b0;
         CAM_ADDR_WR <= '0;
         CAM_DIN     <= '0;
      end else begin
         CAM_WE      <= (state_nxt == WRITE);
         CAM_ADDR_WR <= (state_nxt == WRITE) ? CFG_WR_ADDR : '0;
         CAM_DIN     <= (state_nxt == WRITE) ? CFG_WR_DATA : '0;
      end
   end

   // compare key: captured on accept, held otherwise
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)       CAM_CMP_DIN <= '0;
      else if (lu_acc) CAM_CMP_DIN <= LU_KEY;
   end

   // response register; a match without an exiting tag is dropped
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         LU_RSP_VLD  <= 1'b0;
         LU_RSP_HIT  <= 1'b0;
         LU_RSP_ADDR <= '0;
      end else begin
         LU_RSP_VLD  <= tag_out;
         LU_RSP_HIT  <= tag_out && CAM_MATCH;
         LU_RSP_ADDR <= (tag_out && CAM_MATCH) ? CAM_MATCH_ADDR : '0;
      end
   end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed bench for cam_ctrl with a small behavioural CAM core
// (fixed match latency, BUSY held three cycles after each write).
module tb_cam_ctrl;
   localparam int AW = 5, DW = 16, LAT = 2, SMAX = 8, NV = 6;

   logic          CLK = 1'b0, RSTN = 1'b0;
   logic          CFG_WR_REQ = 1'b0, CFG_WR_ACK;
   logic [AW-1:0] CFG_WR_ADDR = '0;
   logic [DW-1:0] CFG_WR_DATA = '0;
   logic          LU_REQ = 1'b0, LU_RDY, LU_RSP_VLD, LU_RSP_HIT;
   logic [DW-1:0] LU_KEY = '0;
   logic [AW-1:0] LU_RSP_ADDR;
   logic          CAM_WE, CAM_BUSY, CAM_MATCH;
   logic [AW-1:0] CAM_ADDR_WR, CAM_MATCH_ADDR;
   logic [DW-1:0] CAM_DIN, CAM_CMP_DIN;

   int checks = 0, errors = 0;

   always #5 CLK = ~CLK;

   cam_ctrl #(.C_TCAM_ADDR_WIDTH(AW), .C_TCAM_DATA_WIDTH(DW),
              .C_LOOKUP_LATENCY(LAT), .C_WR_STARVE_MAX(SMAX)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .CFG_WR_REQ(CFG_WR_REQ), .CFG_WR_ADDR(CFG_WR_ADDR), .CFG_WR_DATA(CFG_WR_DATA),
      .CFG_WR_ACK(CFG_WR_ACK),
      .LU_REQ(LU_REQ), .LU_KEY(LU_KEY), .LU_RDY(LU_RDY), .LU_RSP_VLD(LU_RSP_VLD),
      .LU_RSP_HIT(LU_RSP_HIT), .LU_RSP_ADDR(LU_RSP_ADDR),
      .CAM_WE(CAM_WE), .CAM_ADDR_WR(CAM_ADDR_WR), .CAM_DIN(CAM_DIN), .CAM_BUSY(CAM_BUSY),
      .CAM_CMP_DIN(CAM_CMP_DIN), .CAM_MATCH(CAM_MATCH), .CAM_MATCH_ADDR(CAM_MATCH_ADDR));

   // ---------------- behavioural CAM core ----------------
   logic [DW-1:0] mem [32];
   logic [31:0]   mval = '0;
   logic [DW-1:0] hist [LAT];
   int            busy_cnt = 0;
   logic          busy_force = 1'b0, match_force = 1'b0;
   logic          m_hit;
   logic [AW-1:0] m_addr;

   // storage, busy timer and compare-key delay line
   always @(posedge CLK) begin
      if (CAM_WE) begin
         mem[CAM_ADDR_WR]  <= CAM_DIN;
         mval[CAM_ADDR_WR] <= 1'b1;
      end
      if (CAM_WE)            busy_cnt <= 3;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      hist[0] <= CAM_CMP_DIN;
      for (int k = LAT - 1; k > 0; k--) hist[k] <= hist[k-1];
   end

   // lowest matching address wins
   always_comb begin
      m_hit  = 1'b0;
      m_addr = '0;
      for (int a = 31; a >= 0; a--)
         if (mval[a] && mem[a] == hist[LAT-1]) begin
            m_hit  = 1'b1;
            m_addr = a[4:0];
         end
   end

   assign CAM_BUSY       = (busy_cnt != 0) || busy_force;
   assign CAM_MATCH      = m_hit || match_force;
   assign CAM_MATCH_ADDR = m_addr;

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"},   32'(LU_RDY),      0);
      chk({tag, "_vld"},   32'(LU_RSP_VLD),  0);
      chk({tag, "_hit"},   32'(LU_RSP_HIT),  0);
      chk({tag, "_raddr"}, 32'(LU_RSP_ADDR), 0);
      chk({tag, "_ack"},   32'(CFG_WR_ACK),  0);
      chk({tag, "_we"},    32'(CAM_WE),      0);
      chk({tag, "_waddr"}, 32'(CAM_ADDR_WR), 0);
      chk({tag, "_din"},   32'(CAM_DIN),     0);
      chk({tag, "_cmp"},   32'(CAM_CMP_DIN), 0);
   endtask

   int            we_n, ack_n, rsp_n, we_t, ack_t, rsp_t;
   logic [AW-1:0] we_a, rsp_a;
   logic [DW-1:0] we_d;
   logic          rsp_h, busy_at_ack, we_rdy;

   // run a write already requested on CFG_WR_* until ACK, logging what happens
   task automatic wait_write();
      we_n = 0; ack_n = 0; rsp_n = 0; we_t = -1; ack_t = -1; rsp_t = -1;
      for (int i = 0; i < 60 && ack_n == 0; i++) begin
         step();
         if (CAM_WE) begin
            we_n++; we_t = i; we_a = CAM_ADDR_WR; we_d = CAM_DIN; we_rdy = LU_RDY;
         end
         if (LU_RSP_VLD) begin
            rsp_n++; rsp_t = i; rsp_h = LU_RSP_HIT; rsp_a = LU_RSP_ADDR;
         end
         if (CFG_WR_ACK) begin
            ack_n++; ack_t = i; busy_at_ack = CAM_BUSY;
         end
      end
      chk("wr_ack_seen", 32'(ack_n), 1);
      step();
      CFG_WR_REQ = 1'b0;
      #1;
      chk("wr_ack_pulse", 32'(CFG_WR_ACK), 0);
   endtask

   typedef struct {
      logic [DW-1:0] key;
      logic          hit;
      logic [AW-1:0] addr;
   } vec_t;

   vec_t vt [NV];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, r, t;
      logic exp_v;

      vt[0] = '{16'h1234, 1'b1, 5'h00};
      vt[1] = '{16'habcd, 1'b1, 5'h0f};
      vt[2] = '{16'h5678, 1'b1, 5'h1e};
      vt[3] = '{16'h1111, 1'b0, 5'h00};
      vt[4] = '{16'h0000, 1'b0, 5'h00};
      vt[5] = '{16'h5678, 1'b1, 5'h1e};

      // reset held 100 cycles
      repeat (100) step();
      chk_zero("rst");
      RSTN = 1'b1;
      #1;
      chk("rdy_after_rst", 32'(LU_RDY), 1);

      // single write with BUSY for three cycles
      CFG_WR_ADDR = 5'h0f; CFG_WR_DATA = 16'habcd; CFG_WR_REQ = 1'b1;
      wait_write();
      chk("w0_we_cnt",   32'(we_n), 1);
      chk("w0_addr",     32'(we_a), 32'h0f);
      chk("w0_data",     32'(we_d), 32'habcd);
      chk("w0_rdy_at_we", 32'(we_rdy), 0);
      chk("w0_ack_delay", 32'(ack_t - we_t), 4);
      chk("w0_busy_at_ack", 32'(busy_at_ack), 0);

      CFG_WR_ADDR = 5'h00; CFG_WR_DATA = 16'h1234; CFG_WR_REQ = 1'b1;
      wait_write();
      chk("w1_addr", 32'(we_a), 32'h00);
      CFG_WR_ADDR = 5'h1e; CFG_WR_DATA = 16'h5678; CFG_WR_REQ = 1'b1;
      wait_write();
      chk("w2_data", 32'(we_d), 32'h5678);

      // back-to-back lookups from the vector table
      for (int i = 0; i < NV + LAT + 4; i++) begin
         if (i < NV) begin LU_REQ = 1'b1; LU_KEY = vt[i].key; end
         else        begin LU_REQ = 1'b0; LU_KEY = '0; end
         #1;
         if (i < NV) chk("lu_rdy", 32'(LU_RDY), 1);
         r = i - (LAT + 2);
         exp_v = (r >= 0 && r < NV);
         chk("lu_vld", 32'(LU_RSP_VLD), 32'(exp_v));
         if (exp_v) begin
            chk("lu_hit",  32'(LU_RSP_HIT),  32'(vt[r].hit));
            chk("lu_addr", 32'(LU_RSP_ADDR), 32'(vt[r].addr));
         end
         step();
      end
      chk("cmp_hold", 32'(CAM_CMP_DIN), 32'(vt[NV-1].key));

      // stray CAM_MATCH with nothing in flight
      match_force = 1'b1;
      repeat (4) begin
         step();
         chk("stray_match", 32'(LU_RSP_VLD), 0);
      end
      match_force = 1'b0;

      // external BUSY blocks lookups in IDLE
      busy_force = 1'b1; LU_REQ = 1'b1; LU_KEY = 16'h1234;
      #1;
      chk("busy_rdy", 32'(LU_RDY), 0);
      repeat (6) begin
         step();
         chk("busy_no_rsp", 32'(LU_RSP_VLD), 0);
      end
      LU_REQ = 1'b0; busy_force = 1'b0;
      #1;
      chk("busy_release_rdy", 32'(LU_RDY), 1);

      // starvation limit: pending write, continuous lookups
      CFG_WR_ADDR = 5'h05; CFG_WR_DATA = 16'h0505; CFG_WR_REQ = 1'b1;
      LU_REQ = 1'b1; LU_KEY = 16'h5678;
      acc = 0; rsp_n = 0; rsp_t = -1; we_n = 0; we_t = -1; ack_t = -1; t = 0;
      while (ack_t < 0 && t < 60) begin
         #1;
         if (LU_RSP_VLD) begin rsp_n++; rsp_t = t; end
         if (LU_RDY) acc++;
         if (CAM_WE) begin we_n++; we_t = t; we_a = CAM_ADDR_WR; end
         if (CFG_WR_ACK) ack_t = t;
         step();
         t++;
      end
      CFG_WR_REQ = 1'b0;
      #1;
      chk("starve_ack_seen", 32'(ack_t >= 0), 1);
      chk("starve_accepts",  32'(acc), SMAX);
      chk("starve_rsps",     32'(rsp_n), SMAX);
      chk("starve_we_cnt",   32'(we_n), 1);
      chk("starve_we_addr",  32'(we_a), 32'h05);
      chk("starve_we_after_rsp", 32'(we_t > rsp_t), 1);
      chk("starve_resume_rdy", 32'(LU_RDY), 1);
      step();
      LU_REQ = 1'b0;
      repeat (6) step();

      // simultaneous write and lookup: lookup first
      CFG_WR_ADDR = 5'h07; CFG_WR_DATA = 16'h0707; CFG_WR_REQ = 1'b1;
      LU_REQ = 1'b1; LU_KEY = 16'habcd;
      #1;
      chk("sim_lu_first", 32'(LU_RDY), 1);
      step();
      LU_REQ = 1'b0;
      wait_write();
      chk("sim_we_addr", 32'(we_a), 32'h07);
      chk("sim_rsp_cnt", 32'(rsp_n), 1);
      chk("sim_rsp_hit", 32'(rsp_h), 1);
      chk("sim_rsp_addr", 32'(rsp_a), 32'h0f);
      chk("sim_rsp_before_we", 32'(rsp_t < we_t), 1);

      // write withdrawn while draining
      LU_REQ = 1'b1; LU_KEY = 16'h1111;
      #1;
      chk("ab_rdy", 32'(LU_RDY), 1);
      step();
      LU_REQ = 1'b0; CFG_WR_ADDR = 5'h03; CFG_WR_DATA = 16'h3333; CFG_WR_REQ = 1'b1;
      step();
      chk("ab_drain_rdy", 32'(LU_RDY), 0);
      CFG_WR_REQ = 1'b0;
      we_n = 0; ack_n = 0;
      repeat (8) begin
         step();
         if (CAM_WE) we_n++;
         if (CFG_WR_ACK) ack_n++;
      end
      chk("ab_no_we",  32'(we_n), 0);
      chk("ab_no_ack", 32'(ack_n), 0);
      chk("ab_idle_rdy", 32'(LU_RDY), 1);

      // reset asserted in WAIT_BUSY
      CFG_WR_ADDR = 5'h02; CFG_WR_DATA = 16'h2222; CFG_WR_REQ = 1'b1;
      we_n = 0;
      for (int i = 0; i < 20 && we_n == 0; i++) begin
         step();
         if (CAM_WE) we_n++;
      end
      chk("rwb_we_seen", 32'(we_n), 1);
      step();
      step();
      chk("rwb_busy", 32'(CAM_BUSY), 1);
      RSTN = 1'b0;
      #1;
      chk_zero("rwb");
      CFG_WR_REQ = 1'b0;
      ack_n = 0;
      repeat (4) begin
         step();
         if (CFG_WR_ACK || CAM_WE) ack_n++;
      end
      chk("rwb_no_ack", 32'(ack_n), 0);
      RSTN = 1'b1;
      #1;
      chk("rwb_rdy", 32'(LU_RDY), 1);
      step();
      chk("rwb_idle_we", 32'(CAM_WE), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cam_ctrl.md
CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 Parameter C_TCAM_ADDR_WIDTH, default 5, CAM entry address width.
REQ-002 Parameter C_TCAM_DATA_WIDTH, default 16, CAM key/data width.
REQ-003 Parameter C_LOOKUP_LATENCY, default 2, cycles from CAM_CMP_DIN driven to CAM_MATCH/CAM_MATCH_ADDR valid (range 1..8).
REQ-004 Parameter C_WR_STARVE_MAX, default 8, consecutive lookup accepts allowed while a write is pending (range 1..255).
REQ-005 Port CLK  in  1  single clock; all logic rising-edge.
REQ-006 Port RSTN  in  1  reset, asynchronous, active-low.
REQ-007 Port CFG_WR_REQ  in  1  write request, held until CFG_WR_ACK.
REQ-008 Port CFG_WR_ADDR  in  C_TCAM_ADDR_WIDTH  entry to write, stable while CFG_WR_REQ.
REQ-009 Port CFG_WR_DATA  in  C_TCAM_DATA_WIDTH  entry value, stable while CFG_WR_REQ.
REQ-010 Port CFG_WR_ACK  out  1  one-cycle pulse: write complete.
REQ-011 Port LU_REQ  in  1  lookup valid.
REQ-012 Port LU_KEY  in  C_TCAM_DATA_WIDTH  lookup key.
REQ-013 Port LU_RDY  out  1  lookup accepted when LU_REQ and LU_RDY high at a rising edge.
REQ-014 Port LU_RSP_VLD  out  1  one-cycle response strobe per accepted lookup.
REQ-015 Port LU_RSP_HIT  out  1  match result, valid with LU_RSP_VLD.
REQ-016 Port LU_RSP_ADDR  out  C_TCAM_ADDR_WIDTH  matching entry, valid with LU_RSP_VLD and LU_RSP_HIT, else 0.
REQ-017 Ports CAM_WE out 1, CAM_ADDR_WR out C_TCAM_ADDR_WIDTH, CAM_DIN out C_TCAM_DATA_WIDTH, CAM_BUSY in 1, CAM_CMP_DIN out C_TCAM_DATA_WIDTH, CAM_MATCH in 1, CAM_MATCH_ADDR in C_TCAM_ADDR_WIDTH: connect to the CAM core.

Function
REQ-018 State machine SHALL have states IDLE, DRAIN, WRITE, WAIT_BUSY.
REQ-019 IDLE: LU_RDY=1 unless a write is pending and starve counter equals C_WR_STARVE_MAX; on accept, CAM_CMP_DIN registers LU_KEY (driven from next cycle) and an in-flight tag enters a C_LOOKUP_LATENCY-deep shift register.
REQ-020 Arbitration: lookup wins over a simultaneous write request; starve counter increments per lookup accepted while CFG_WR_REQ high, saturates at C_WR_STARVE_MAX, clears on entry to WRITE.
REQ-021 IDLE->DRAIN when CFG_WR_REQ high and (no LU_REQ or starve counter at max); LU_RDY=0 from DRAIN through WAIT_BUSY.
REQ-022 DRAIN->WRITE when no in-flight tags remain (same cycle allowed if already empty).
REQ-023 WRITE lasts exactly one cycle: CAM_WE=1, CAM_ADDR_WR=CFG_WR_ADDR, CAM_DIN=CFG_WR_DATA, all registered; CAM_WE=0, CAM_ADDR_WR=0, CAM_DIN=0 in all other states.
REQ-024 WAIT_BUSY: minimum one cycle (CAM_BUSY may assert one cycle after CAM_WE); exit to IDLE on first cycle CAM_BUSY=0 after that minimum, pulsing CFG_WR_ACK for exactly that cycle.
REQ-025 CFG_WR_REQ withdrawn before WRITE (in DRAIN): return to IDLE, no CAM_WE, no ACK; after WRITE, sequence completes regardless.
REQ-026 Lookup latency: key accepted at edge N -> LU_RSP_VLD high in cycle N+1+C_LOOKUP_LATENCY with registered CAM_MATCH/CAM_MATCH_ADDR; back-to-back accepts give back-to-back responses, one per accept, in order.
REQ-027 CAM_MATCH while no tag exits the shift register SHALL be ignored (no LU_RSP_VLD).
REQ-028 CAM_CMP_DIN holds last accepted key when idle; CAM_BUSY high in IDLE (external) SHALL force LU_RDY=0.

Reset
REQ-029 RSTN low at any time, including mid-WRITE/WAIT_BUSY: state IDLE, shift register and starve counter cleared; LU_RDY, LU_RSP_VLD, LU_RSP_HIT, CFG_WR_ACK, CAM_WE = 0; LU_RSP_ADDR, CAM_ADDR_WR, CAM_DIN, CAM_CMP_DIN = 0.
REQ-030 First lookup/write may be accepted on the first rising edge after RSTN deasserts; LU_RDY=1 in the first cycle after release.

Verification
REQ-031 Reset held 100 cycles -> all outputs 0; release -> LU_RDY=1 next cycle.
REQ-032 Write addr 0x0f data 0xabcd, CAM model BUSY 3 cycles -> single CAM_WE pulse with 0x0f/0xabcd, CFG_WR_ACK one cycle after BUSY falls.
REQ-033 After writes 0x00=0x1234, 0x0f=0xabcd, 0x1e=0x5678: lookups 0x1234, 0xabcd, 0x5678, 0x1111 back-to-back -> four consecutive responses HIT/ADDR 1/0x00, 1/0x0f, 1/0x1e, 0/0x00 at latency 1+C_LOOKUP_LATENCY.
REQ-034 Write pending, continuous LU_REQ, C_WR_STARVE_MAX=8 -> exactly 8 lookups accepted, LU_RDY drops, CAM_WE only after last response, lookups resume after ACK.
REQ-035 CFG_WR_REQ and LU_REQ rise same cycle in IDLE -> lookup accepted first; then write proceeds when LU_REQ drops.
REQ-036 RSTN asserted in WAIT_BUSY -> no CFG_WR_ACK, all outputs 0 within the same cycle, IDLE after release.
